timekeeper_dp: RTL and testbench

Parametrised successor to the fixed 100 Hz clock datapath. It generates a centisecond tick from clk and drives a cascaded centisecond/second/minute/hour counter chain. Over the previous datapath it adds:
- run/pause gating and synchronous clear;
- per-field increment and decrement for time setting;
- a 12/24-hour display mode with a PM flag;
- a day-rollover pulse.

It sits between the button/UART command decoder and the FND/UART display formatter.

---
 rtl/tk_pkg.sv | 25 ++
 rtl/timekeeper_dp_if.sv | 25 ++
 rtl/tk_field_counter.sv | 33 +++
 rtl/timekeeper_dp.sv | 89 ++++++++
 tb/tb_timekeeper_dp.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tk_pkg.sv
// Shared constants and helpers for the timekeeper datapath.
package tk_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } tk_sel_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  // 0 -> 12, 13..23 -> h-12, 1..12 unchanged
  function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
    if (h == 5'd0)
      return 5'd12;
    else if (h > 5'd12)
      return h - 5'd12;
    else
      return h;
  endfunction

endpackage

// File: rtl/timekeeper_dp_if.sv
// Command/display bundle between the command decoder and the timekeeper datapath.
interface timekeeper_dp_if;
    logic       i_run;
    logic       i_clear;
    logic       i_mode12;
    logic [1:0] i_set_sel;
    logic       i_inc;
    logic       i_dec;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_pm;
    logic       o_day_tick;

    modport master (
        output i_run, i_clear, i_mode12, i_set_sel, i_inc, i_dec,
        input  o_msec, o_sec, o_min, o_hour, o_pm, o_day_tick
    );

    modport slave (
        input  i_run, i_clear, i_mode12, i_set_sel, i_inc, i_dec,
        output o_msec, o_sec, o_min, o_hour, o_pm, o_day_tick
    );
endinterface

// File: rtl/tk_field_counter.sv
// One modulo-(MAX+1) time field: clear > inc/dec set > carry advance.
module tk_field_counter #(
    parameter int unsigned MAX  = 59,
    parameter int unsigned INIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    input  logic                       dec,
    input  logic                       carry_in,
    output logic [$clog2(MAX+1)-1:0]   value,
    output logic                       carry_out
);
    localparam int unsigned W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] INIT_V = W'(INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= INIT_V;
        else if (clr)
            value <= INIT_V;
        else if (inc && !dec)
            value <= (value == MAX_V) ? '0 : value + W'(1);
        else if (dec && !inc)
            value <= (value == '0) ? MAX_V : value - W'(1);
        else if (carry_in)
            value <= (value == MAX_V) ? '0 : value + W'(1);
    end

    assign carry_out = carry_in && (value == MAX_V);
endmodule

// File: rtl/timekeeper_dp.sv
// Centisecond prescaler feeding a msec/sec/min/hour cascade with set, clear and 12/24 h display.
module timekeeper_dp
    import tk_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned INIT_HOUR = 12,
    parameter int unsigned INIT_MIN  = 0,
    parameter int unsigned INIT_SEC  = 0
) (
    input logic            clk,
    input logic            rst,
    timekeeper_dp_if.slave bus
);
    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned MW  = $clog2(TICK_HZ);

    logic [PW-1:0] presc;
    logic          tick;
    logic          set_taken;
    logic          tick_eff;
    logic          ms_carry, sec_carry, min_carry, hour_carry;
    logic [MW-1:0] msec_v;
    logic [5:0]    sec_v, min_v;
    logic [4:0]    hour_v;
    logic          day_tick;

    assign tick = bus.i_run && !bus.i_clear && (presc == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (bus.i_clear)
            presc <= '0;
        else if (bus.i_run)
            presc <= tick ? '0 : presc + PW'(1);
    end

    // A taken set swallows this cycle's tick; the prescaler still wraps.
    assign set_taken = (bus.i_set_sel != SEL_NONE) && (bus.i_inc ^ bus.i_dec);
    assign tick_eff  = tick && !set_taken;

    tk_field_counter #(.MAX(TICK_HZ - 1), .INIT(0)) u_msec (
        .clk(clk), .rst(rst), .clr(bus.i_clear || set_taken),
        .inc(1'b0), .dec(1'b0), .carry_in(tick_eff),
        .value(msec_v), .carry_out(ms_carry)
    );

    tk_field_counter #(.MAX(SEC_MAX), .INIT(INIT_SEC)) u_sec (
        .clk(clk), .rst(rst), .clr(bus.i_clear),
        .inc(bus.i_set_sel == SEL_SEC && bus.i_inc),
        .dec(bus.i_set_sel == SEL_SEC && bus.i_dec),
        .carry_in(ms_carry),
        .value(sec_v), .carry_out(sec_carry)
    );

    tk_field_counter #(.MAX(MIN_MAX), .INIT(INIT_MIN)) u_min (
        .clk(clk), .rst(rst), .clr(bus.i_clear),
        .inc(bus.i_set_sel == SEL_MIN && bus.i_inc),
        .dec(bus.i_set_sel == SEL_MIN && bus.i_dec),
        .carry_in(sec_carry),
        .value(min_v), .carry_out(min_carry)
    );

    tk_field_counter #(.MAX(HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
        .clk(clk), .rst(rst), .clr(bus.i_clear),
        .inc(bus.i_set_sel == SEL_HOUR && bus.i_inc),
        .dec(bus.i_set_sel == SEL_HOUR && bus.i_dec),
        .carry_in(min_carry),
        .value(hour_v), .carry_out(hour_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            day_tick <= 1'b0;
        else if (bus.i_clear)
            day_tick <= 1'b0;
        else
            day_tick <= hour_carry;
    end

    assign bus.o_msec     = 7'(msec_v);
    assign bus.o_sec      = sec_v;
    assign bus.o_min      = min_v;
    assign bus.o_hour     = bus.i_mode12 ? hour_to_12h(hour_v) : hour_v;
    assign bus.o_pm       = (hour_v >= 5'd12);
    assign bus.o_day_tick = day_tick;
endmodule

// File: tb/tb_timekeeper_dp.sv
// Scoreboard bench for timekeeper_dp at CLK_FREQ=1000, TICK_HZ=100 (10 clk per centisecond).
module tb_timekeeper_dp;
    import tk_pkg::*;

    typedef struct packed {
        logic [6:0] ms;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic       pm;
        logic       day;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timekeeper_dp_if bus ();

    timekeeper_dp #(
        .CLK_FREQ (1000),
        .TICK_HZ  (100),
        .INIT_HOUR(12),
        .INIT_MIN (0),
        .INIT_SEC (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string nm, input int ms, input int s, input int m,
                                input int h, input bit pm, input bit day);
        exp_t e;
        e.ms  = 7'(ms);
        e.s   = 6'(s);
        e.m   = 6'(m);
        e.h   = 5'(h);
        e.pm  = pm;
        e.day = day;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_op(input logic [1:0] sel, input bit up);
        bus.i_set_sel = sel;
        if (up) bus.i_inc = 1'b1;
        else    bus.i_dec = 1'b1;
        step(1);
        bus.i_inc     = 1'b0;
        bus.i_dec     = 1'b0;
        bus.i_set_sel = SEL_NONE;
    endtask

    // Monitor: one expectation per falling edge, mid-cycle away from the active edge.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {bus.o_msec, bus.o_sec, bus.o_min, bus.o_hour, bus.o_pm, bus.o_day_tick};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL %s: got %0d:%0d:%0d.%0d pm=%b day=%b, want %0d:%0d:%0d.%0d pm=%b day=%b",
                             nm, got.h, got.m, got.s, got.ms, got.pm, got.day,
                             e.h, e.m, e.s, e.ms, e.pm, e.day);
                end
            end
        end
    end

    initial begin
        bus.i_run     = 1'b1;
        bus.i_clear   = 1'b0;
        bus.i_mode12  = 1'b0;
        bus.i_set_sel = SEL_NONE;
        bus.i_inc     = 1'b0;
        bus.i_dec     = 1'b0;

        // 1: reset state and one second of counting
        step(2);
        expect_state("reset", 0, 0, 0, 12, 1, 0);
        rst = 1'b0;
        step(999);
        expect_state("run_999", 99, 0, 0, 12, 1, 0);
        step(1);
        expect_state("run_1000", 0, 1, 0, 12, 1, 0);

        // 3: pause 5 clk into a period; resume finishes the remaining 5
        step(5);
        bus.i_run = 1'b0;
        step(50);
        expect_state("paused", 0, 1, 0, 12, 1, 0);
        bus.i_run = 1'b1;
        step(4);
        expect_state("resume_4", 0, 1, 0, 12, 1, 0);
        step(1);
        expect_state("resume_5", 1, 1, 0, 12, 1, 0);

        // 4: field set wrap, no carry/borrow, msec zeroed
        bus.i_run = 1'b0;
        set_op(SEL_SEC, 1'b0);
        set_op(SEL_SEC, 1'b0);
        expect_state("sec_dec_wrap", 0, 59, 0, 12, 1, 0);
        set_op(SEL_SEC, 1'b1);
        expect_state("sec_inc_wrap", 0, 0, 0, 12, 1, 0);
        for (int i = 0; i < 12; i++) set_op(SEL_HOUR, 1'b0);
        expect_state("hour_to_0", 0, 0, 0, 0, 0, 0);
        set_op(SEL_HOUR, 1'b0);
        expect_state("hour_dec_wrap", 0, 0, 0, 23, 1, 0);
        step(1);
        bus.i_mode12 = 1'b1;
        expect_state("hour23_12h", 0, 0, 0, 11, 1, 0);
        step(1);
        bus.i_mode12 = 1'b0;

        // 2: preload 23:59:59.99 and roll the day
        set_op(SEL_MIN, 1'b0);
        set_op(SEL_SEC, 1'b0);
        bus.i_run = 1'b1;
        step(990);
        expect_state("preload", 99, 59, 59, 23, 1, 0);
        step(9);
        expect_state("pre_rollover", 99, 59, 59, 23, 1, 0);
        step(1);
        expect_state("rollover", 0, 0, 0, 0, 0, 1);
        step(1);
        expect_state("day_tick_clear", 0, 0, 0, 0, 0, 0);

        // 5: set coincident with tick discards the tick; clear beats set
        step(8);
        bus.i_set_sel = SEL_MIN;
        bus.i_inc     = 1'b1;
        step(1);
        bus.i_inc     = 1'b0;
        bus.i_set_sel = SEL_NONE;
        expect_state("set_vs_tick", 0, 0, 1, 0, 0, 0);
        step(10);
        expect_state("presc_wrapped", 1, 0, 1, 0, 0, 0);
        bus.i_clear   = 1'b1;
        bus.i_set_sel = SEL_MIN;
        bus.i_inc     = 1'b1;
        step(1);
        bus.i_clear   = 1'b0;
        bus.i_inc     = 1'b0;
        bus.i_set_sel = SEL_NONE;
        expect_state("clear_vs_inc", 0, 0, 0, 12, 1, 0);
        step(10);
        expect_state("after_clear", 1, 0, 0, 12, 1, 0);

        // 6: asynchronous reset between edges
        step(3);
        #2;
        rst = 1'b1;
        expect_state("async_rst", 0, 0, 0, 12, 1, 0);
        step(1);
        rst = 1'b0;
        step(9);
        expect_state("post_rst_9", 0, 0, 0, 12, 1, 0);
        step(1);
        expect_state("post_rst_10", 1, 0, 0, 12, 1, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
